// File: rtl/ram_sweep_ctrl.sv
// Fill-and-readback sweep controller for a single-port RAM.
// Writes an address-derived pattern, reads it back and scores mismatches.
module ram_sweep_ctrl #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16,
  parameter int START_ADDR = 2,
  parameter int STRIDE = 2048,
  parameter logic [DATA_W-1:0] PAT_XOR = 16'h0000,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] ram_out,
  output logic [DATA_W-1:0] ram_in,
  output logic [ADDR_W-1:0] ram_add,
  output logic              ram_read,
  output logic              ram_write,
  output logic              ram_en1,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        err_count,
  output logic [ADDR_W-1:0] fail_addr
);

  typedef enum logic [2:0] {
    IDLE, WRITE, READ, DRAIN, DONE
  } state_t;

  localparam logic [ADDR_W:0] STEP =
    (ADDR_W+1)'(STRIDE);
  localparam logic [ADDR_W-1:0] SADDR =
    ADDR_W'(START_ADDR);

  function automatic logic [DATA_W-1:0] pat(
    input logic [ADDR_W-1:0] a
  );
    return DATA_W'(a) ^ PAT_XOR;
  endfunction

  state_t state, state_n;

  logic [ADDR_W:0]   sum;
  logic [DATA_W-1:0] in_n;
  logic [ADDR_W-1:0] add_n, fail_n;
  logic              rd_n, wr_n, en_n;
  logic              busy_n, done_n, pass_n;
  logic [7:0]        err_n;
  logic [1:0]        cnt, cnt_n;
  logic              issue, hit;

  logic [RD_LAT-1:0] pv;
  logic [DATA_W-1:0] pd [RD_LAT];
  logic [ADDR_W-1:0] pa [RD_LAT];

  assign sum   = {1'b0, ram_add} + STEP;
  assign issue = ram_en1 & ram_read & ~ram_write;
  assign hit   = pv[RD_LAT-1] &&
                 (ram_out != pd[RD_LAT-1]);

  // Expected word and address ride alongside each read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pd[i] <= '0;
        pa[i] <= '0;
      end
    end else begin
      pv[0] <= issue;
      pd[0] <= pat(ram_add);
      pa[0] <= ram_add;
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
        pa[i] <= pa[i-1];
      end
    end
  end

  always_comb begin
    state_n = state;
    add_n   = ram_add;
    in_n    = '0;
    rd_n    = 1'b0;
    wr_n    = 1'b0;
    en_n    = 1'b0;
    busy_n  = busy;
    done_n  = 1'b0;
    pass_n  = pass;
    cnt_n   = cnt;
    err_n   = (hit && err_count != 8'hff) ?
              err_count + 8'd1 : err_count;
    fail_n  = (hit && err_count == 8'd0) ?
              pa[RD_LAT-1] : fail_addr;
    unique case (state)
      IDLE, DONE: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        if (start) begin
          state_n = WRITE;
          add_n   = SADDR;
          in_n    = pat(SADDR);
          {en_n, rd_n, wr_n} = 3'b111;
          busy_n  = 1'b1;
          pass_n  = 1'b0;
          err_n   = '0;
          fail_n  = '0;
        end
      end
      WRITE: begin
        if (sum[ADDR_W]) begin
          state_n = READ;
          add_n   = SADDR;
          {en_n, rd_n} = 2'b11;
        end else begin
          add_n = sum[ADDR_W-1:0];
          in_n  = pat(sum[ADDR_W-1:0]);
          {en_n, rd_n, wr_n} = 3'b111;
        end
      end
      READ: begin
        if (sum[ADDR_W]) begin
          state_n = DRAIN;
          cnt_n   = 2'(RD_LAT - 1);
        end else begin
          add_n = sum[ADDR_W-1:0];
          {en_n, rd_n} = 2'b11;
        end
      end
      DRAIN: begin
        // Final compare lands on this edge, so score it in pass.
        if (cnt == 2'd0) begin
          state_n = DONE;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          pass_n  = (err_n == 8'd0);
        end else begin
          cnt_n = cnt - 2'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ram_in    <= '0;
      ram_add   <= '0;
      ram_read  <= 1'b0;
      ram_write <= 1'b0;
      ram_en1   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_addr <= '0;
      cnt       <= '0;
    end else begin
      state     <= state_n;
      ram_in    <= in_n;
      ram_add   <= add_n;
      ram_read  <= rd_n;
      ram_write <= wr_n;
      ram_en1   <= en_n;
      busy      <= busy_n;
      done      <= done_n;
      pass      <= pass_n;
      err_count <= err_n;
      fail_addr <= fail_n;
      cnt       <= cnt_n;
    end
  end

endmodule

// File: tb/tb_ram_sweep_ctrl.sv
// Bench for ram_sweep_ctrl: default and edge-parameter instances,
// each driving a behavioural RAM with injectable read faults.
module tb_ram_sweep_ctrl;

  localparam int AW = 14;
  localparam int DW = 16;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic start_a = 1'b0, start_b = 1'b0;
  logic [DW-1:0] out_a, out_b, in_a, in_b;
  logic [AW-1:0] add_a, add_b, fa_a, fa_b;
  logic rd_a, wr_a, en_a, busy_a, done_a, pass_a;
  logic rd_b, wr_b, en_b, busy_b, done_b, pass_b;
  logic [7:0] ec_a, ec_b;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] mem_a [DEPTH];
  logic [DW-1:0] mem_b [DEPTH];
  logic [DW-1:0] flip_a [DEPTH];
  logic [DW-1:0] flip_b [DEPTH];
  logic [DW-1:0] q_b [3];

  ram_sweep_ctrl u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a),
    .ram_out(out_a), .ram_in(in_a), .ram_add(add_a),
    .ram_read(rd_a), .ram_write(wr_a), .ram_en1(en_a),
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(ec_a), .fail_addr(fa_a)
  );

  ram_sweep_ctrl #(
    .START_ADDR(16380), .STRIDE(1),
    .PAT_XOR(16'hFFFF), .RD_LAT(3)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b),
    .ram_out(out_b), .ram_in(in_b), .ram_add(add_b),
    .ram_read(rd_b), .ram_write(wr_b), .ram_en1(en_b),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(ec_b), .fail_addr(fa_b)
  );

  always @(posedge clk) begin
    if (en_a && wr_a) mem_a[add_a] <= in_a;
    if (en_a && rd_a && !wr_a)
      out_a <= mem_a[add_a] ^ flip_a[add_a];
    else
      out_a <= '0;
  end

  always @(posedge clk) begin
    if (en_b && wr_b) mem_b[add_b] <= in_b;
    if (en_b && rd_b && !wr_b)
      q_b[0] <= mem_b[add_b] ^ flip_b[add_b];
    else
      q_b[0] <= '0;
    q_b[1] <= q_b[0];
    q_b[2] <= q_b[1];
  end
  assign out_b = q_b[2];

  logic [2:0]    o_cmd;
  logic [AW-1:0] o_add, o_fa;
  logic [DW-1:0] o_din;
  logic          o_busy, o_done, o_pass;
  logic [7:0]    o_ec;

  task automatic grab(input bit sel);
    if (sel) begin
      o_cmd = {en_b, rd_b, wr_b}; o_add = add_b;
      o_din = in_b; o_busy = busy_b; o_done = done_b;
      o_pass = pass_b; o_ec = ec_b; o_fa = fa_b;
    end else begin
      o_cmd = {en_a, rd_a, wr_a}; o_add = add_a;
      o_din = in_a; o_busy = busy_a; o_done = done_a;
      o_pass = pass_a; o_ec = ec_a; o_fa = fa_a;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic set_start(input bit sel, input logic v);
    if (sel) start_b = v; else start_a = v;
  endtask

  task automatic zero_chk(input bit sel, input string tag);
    grab(sel);
    chk({tag, ".cmd"}, 32'(o_cmd), 0);
    chk({tag, ".add"}, 32'(o_add), 0);
    chk({tag, ".din"}, 32'(o_din), 0);
    chk({tag, ".busy"}, 32'(o_busy), 0);
    chk({tag, ".done"}, 32'(o_done), 0);
    chk({tag, ".pass"}, 32'(o_pass), 0);
    chk({tag, ".err"}, 32'(o_ec), 0);
    chk({tag, ".fail"}, 32'(o_fa), 0);
  endtask

  task automatic clear_flips();
    for (int i = 0; i < DEPTH; i++) begin
      flip_a[i] = '0;
      flip_b[i] = '0;
    end
  endtask

  // Called at the falling edge of cycle 1; walks the sweep against
  // the address list, then checks one cycle past done.
  task automatic sweep(input bit sel, input bit pulse5,
                       input bit keep);
    int sa, st, lat, n, dcyc, eerr, efail;
    logic [DW-1:0] px, f;
    int addrs[$];
    sa  = sel ? 16380 : 2;
    st  = sel ? 1 : 2048;
    lat = sel ? 3 : 1;
    px  = sel ? 16'hFFFF : 16'h0000;
    for (int a = sa; a < DEPTH; a += st) addrs.push_back(a);
    n = addrs.size();
    dcyc = 2 * n + lat + 1;
    eerr = 0;
    efail = 0;
    foreach (addrs[i]) begin
      f = sel ? flip_b[addrs[i]] : flip_a[addrs[i]];
      if (f != 0) begin
        if (eerr == 0) efail = addrs[i];
        if (eerr < 255) eerr++;
      end
    end
    for (int c = 1; c <= dcyc; c++) begin
      grab(sel);
      chk("cmd", 32'(o_cmd),
          c <= n ? 3'b111 : (c <= 2 * n ? 3'b110 : 3'b000));
      if (c <= 2 * n)
        chk("add", 32'(o_add), addrs[(c - 1) % n]);
      if (c <= n)
        chk("din", 32'(o_din), 32'(16'(addrs[c - 1]) ^ px));
      chk("busy", 32'(o_busy), 32'(c < dcyc));
      chk("done", 32'(o_done), 32'(c == dcyc));
      if (c == 1) begin
        chk("clr.pass", 32'(o_pass), 0);
        chk("clr.err", 32'(o_ec), 0);
        chk("clr.fail", 32'(o_fa), 0);
      end
      if (c == dcyc) begin
        chk("pass", 32'(o_pass), 32'(eerr == 0));
        chk("err", 32'(o_ec), eerr);
        chk("fail", 32'(o_fa), efail);
      end
      if (pulse5 && c == 5) set_start(sel, 1'b1);
      if (pulse5 && c == 6 && !keep) set_start(sel, 1'b0);
      @(negedge clk);
    end
    grab(sel);
    if (keep) begin
      chk("restart.cmd", 32'(o_cmd), 3'b111);
      chk("restart.add", 32'(o_add), sa);
    end else begin
      chk("post.cmd", 32'(o_cmd), 0);
      chk("post.busy", 32'(o_busy), 0);
      chk("post.done", 32'(o_done), 0);
      chk("post.pass", 32'(o_pass), 32'(eerr == 0));
      chk("post.err", 32'(o_ec), eerr);
      chk("post.fail", 32'(o_fa), efail);
    end
  endtask

  task automatic kick(input bit sel);
    set_start(sel, 1'b1);
    @(negedge clk);
    set_start(sel, 1'b0);
  endtask

  initial begin
    int k;
    clear_flips();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    zero_chk(0, "rst.a");
    zero_chk(1, "rst.b");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    zero_chk(0, "idle.a");
    zero_chk(1, "idle.b");

    kick(0);
    sweep(0, 0, 0);

    // Async reset mid-cycle clears held results immediately.
    #2 rst_n = 1'b0;
    #1 zero_chk(0, "async.a");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    flip_a[4098]  = 16'h0001;
    flip_a[10242] = 16'h0001;
    kick(0);
    sweep(0, 0, 0);

    clear_flips();
    flip_a[14338] = 16'h0100;
    kick(0);
    sweep(0, 1, 0);

    clear_flips();
    set_start(0, 1'b1);
    @(negedge clk);
    sweep(0, 0, 1);
    set_start(0, 1'b0);
    sweep(0, 0, 0);

    kick(1);
    sweep(1, 0, 0);
    flip_b[16383] = 16'h8000;
    kick(1);
    sweep(1, 0, 0);

    for (int r = 0; r < 4; r++) begin
      clear_flips();
      k = $urandom_range(0, 3);
      for (int j = 0; j < k; j++) begin
        flip_a[2 + 2048 * $urandom_range(0, 7)] =
          16'(1) << $urandom_range(0, 15);
        flip_b[16380 + $urandom_range(0, 3)] =
          16'(1) << $urandom_range(0, 15);
      end
      kick(0);
      sweep(0, 0, 0);
      kick(1);
      sweep(1, 0, 0);
    end

    // Reset during the read phase drops the sweep with no done.
    clear_flips();
    flip_a[2] = 16'h0004;
    kick(0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1 zero_chk(0, "rstrd");
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      grab(0);
      chk("rstrd.done", 32'(o_done), 0);
      chk("rstrd.cmd", 32'(o_cmd), 0);
    end
    flip_a[2] = 16'h0000;
    kick(0);
    sweep(0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
